k_and_s_control_unit: RTL
=========================

# k_and_s_control_unit

Multi-cycle control FSM of the K&S processor. It consumes the `decoded_instruction_type` value produced by the instruction decoder from the instruction register, plus the registered ALU flags. It drives every datapath and memory control strobe to sequence fetch, decode, execute and write-back. It sits directly downstream of the decoder and upstream of the datapath/RAM control inputs.

## Interface
No parameters. Encodings come from `k_and_s_pkg`.
- `clk`  in  1  single system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `decoded_instruction`  in  5  `decoded_instruction_type`; valid from the cycle after `ir_enable`
- `zero_flag`  in  1  registered zero flag of the last flag-updating ALU op
- `neg_flag`  in  1  registered negative flag
- `ov_flag`  in  1  registered signed-overflow flag
- `branch`  out  1  PC loads the branch target instead of PC+1
- `pc_enable`  out  1  PC register write strobe
- `ir_enable`  out  1  IR write strobe
- `addr_sel`  out  1  memory address: 0 = PC, 1 = IR address field
- `c_sel`  out  1  register-file write data: 0 = ALU result, 1 = memory data
- `operation`  out  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
- `write_reg_enable`  out  1  register-file write strobe
- `flags_reg_enable`  out  1  flags register write strobe
- `ram_write_enable`  out  1  data memory write strobe
- `halt`  out  1  processor halted

## Operation
- States: FETCH, LATCH_IR, DECODE, EXEC, LOAD_ADDR, LOAD_WB, STORE, BRANCH, HALT.
- Outputs are Moore, decoded from the state and from `instr_q`, a 5-bit copy of `decoded_instruction` registered in DECODE. Any strobe not listed for a state is 0.
- FETCH:
  - Outputs: `addr_sel`=0 (synchronous RAM read of PC).
  - Next state: LATCH_IR.
- LATCH_IR:
  - Outputs: `ir_enable`=1, `pc_enable`=1, `branch`=0 (PC <- PC+1).
  - Next state: DECODE.
- DECODE:
  - Registers `instr_q` and evaluates branch conditions.
  - NOP, and the undefined encodings 16..31 -> FETCH.
  - MOVE, ADD, SUB, AND, OR -> EXEC.
  - LOAD -> LOAD_ADDR.
  - STORE -> STORE.
  - HALT -> HALT.
  - BRANCH -> BRANCH (unconditional).
  - Conditional branches -> BRANCH if taken, else FETCH. Taken conditions:
    - BZERO: `zero_flag`=1; BNZERO: `zero_flag`=0.
    - BNEG: `neg_flag`=1; BNNEG: `neg_flag`=0.
    - BOV: `ov_flag`=1; BNOV: `ov_flag`=0.
  - Flags are sampled in DECODE only.
- EXEC:
  - Outputs: `write_reg_enable`=1, `c_sel`=0.
  - ADD/SUB/AND/OR: `operation`=00/01/10/11, `flags_reg_enable`=1.
  - MOVE: `operation`=11 (the datapath routes the source to both ALU inputs), `flags_reg_enable`=0.
  - Next state: FETCH.
- LOAD_ADDR:
  - Outputs: `addr_sel`=1.
  - Next state: LOAD_WB.
- LOAD_WB:
  - Outputs: `addr_sel`=1, `c_sel`=1, `write_reg_enable`=1, `flags_reg_enable`=0.
  - Next state: FETCH.
- STORE:
  - Outputs: `addr_sel`=1, `ram_write_enable`=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: `branch`=1, `pc_enable`=1.
  - Next state: FETCH.
- HALT:
  - Outputs: `halt`=1, all other strobes 0.
  - Stays in HALT until `rst`.
- `operation` outside EXEC is 00.

## Timing
- Reset: `rst`=1 at a rising edge forces state=FETCH and `instr_q`=NOP. All outputs read 0 in the following cycle, including `halt`.
- Reset mid-instruction, including during STORE or LOAD_WB: the pending strobe is dropped in the cycle after the edge. No partial write is repeated.
- Reset while in HALT returns to FETCH.
- Cycles per instruction, FETCH to the next FETCH:
  - NOP / undefined: 3
  - Branch not taken: 3
  - MOVE / ALU: 4
  - STORE: 4
  - Branch taken: 4
  - LOAD: 5
- `decoded_instruction` must be stable throughout DECODE. Changes in other states are ignored.
- Flags written in EXEC are visible to a branch decoded in the very next instruction.
- In LATCH_IR, `pc_enable` and `ir_enable` are asserted together for exactly one cycle per instruction.

## Test plan
- Reset, then NOP -> `ir_enable` and `pc_enable` high in cycle 2 only, back to FETCH at cycle 4. `rst` held 3 cycles -> all outputs 0 throughout.
- ADD, SUB, AND, OR, MOVE in sequence -> EXEC `operation`=00,01,10,11,11. `flags_reg_enable`=1,1,1,1,0. `write_reg_enable`=1 exactly once per instruction.
- LOAD then STORE:
  - LOAD: `addr_sel`=1 for 2 cycles, `c_sel`=1 with `write_reg_enable` in cycle 5.
  - STORE: `ram_write_enable`=1 for exactly 1 cycle, in cycle 4.
- BZERO with `zero_flag`=1 -> `branch`=`pc_enable`=1 in cycle 4.
- BZERO with `zero_flag`=0 -> next FETCH at cycle 4 and `branch` never asserted.
- Repeat the taken/not-taken check for BNZERO, BNEG, BNNEG, BOV, BNOV.
- HALT -> `halt`=1 from cycle 4, held for 20 cycles with no other strobes. Assert `rst` -> `halt`=0 and the fetch of the next instruction resumes.
- Encoding 5'd20 -> behaves as NOP (3 cycles, no writes).
- `rst` asserted during STORE -> `ram_write_enable` low the next cycle, state FETCH.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared encodings for the K&S processor: decoder instruction types and ALU operations.
package k_and_s_pkg;

  typedef enum logic [4:0] {
    InstrNop    = 5'd0,
    InstrMove   = 5'd1,
    InstrAdd    = 5'd2,
    InstrSub    = 5'd3,
    InstrAnd    = 5'd4,
    InstrOr     = 5'd5,
    InstrLoad   = 5'd6,
    InstrStore  = 5'd7,
    InstrBranch = 5'd8,
    InstrBzero  = 5'd9,
    InstrBnzero = 5'd10,
    InstrBneg   = 5'd11,
    InstrBnneg  = 5'd12,
    InstrBov    = 5'd13,
    InstrBnov   = 5'd14,
    InstrHalt   = 5'd15
  } decoded_instruction_type;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpOr  = 2'b11;

endpackage

// File: rtl/k_and_s_control_unit.sv
// Multi-cycle control FSM of the K&S processor: sequences fetch, decode, execute and
// write-back strobes for the datapath and data memory.
module k_and_s_control_unit
  import k_and_s_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] decoded_instruction,
  input  logic       zero_flag,
  input  logic       neg_flag,
  input  logic       ov_flag,
  output logic       branch,
  output logic       pc_enable,
  output logic       ir_enable,
  output logic       addr_sel,
  output logic       c_sel,
  output logic [1:0] operation,
  output logic       write_reg_enable,
  output logic       flags_reg_enable,
  output logic       ram_write_enable,
  output logic       halt
);

  typedef enum logic [3:0] {
    StFetch,
    StLatchIr,
    StDecode,
    StExec,
    StLoadAddr,
    StLoadWb,
    StStore,
    StBranch,
    StHalt
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] instr_q;
  logic       branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      instr_q <= InstrNop;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        instr_q <= decoded_instruction;
      end
    end
  end

  // Conditional branch resolution; only consulted while in DECODE.
  always_comb begin
    branch_taken = 1'b0;
    case (decoded_instruction)
      InstrBzero:  branch_taken = zero_flag;
      InstrBnzero: branch_taken = ~zero_flag;
      InstrBneg:   branch_taken = neg_flag;
      InstrBnneg:  branch_taken = ~neg_flag;
      InstrBov:    branch_taken = ov_flag;
      InstrBnov:   branch_taken = ~ov_flag;
      default:     branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   state_d = StLatchIr;
      StLatchIr: state_d = StDecode;
      StDecode: begin
        case (decoded_instruction)
          InstrMove, InstrAdd, InstrSub, InstrAnd, InstrOr: state_d = StExec;
          InstrLoad:   state_d = StLoadAddr;
          InstrStore:  state_d = StStore;
          InstrHalt:   state_d = StHalt;
          InstrBranch: state_d = StBranch;
          InstrBzero, InstrBnzero, InstrBneg, InstrBnneg, InstrBov, InstrBnov:
            state_d = branch_taken ? StBranch : StFetch;
          default:     state_d = StFetch;
        endcase
      end
      StExec:     state_d = StFetch;
      StLoadAddr: state_d = StLoadWb;
      StLoadWb:   state_d = StFetch;
      StStore:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StHalt:     state_d = StHalt;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = OpAdd;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    unique case (state_q)
      StFetch:  addr_sel = 1'b0;
      StLatchIr: begin
        ir_enable = 1'b1;
        pc_enable = 1'b1;
      end
      StDecode: ;
      StExec: begin
        write_reg_enable = 1'b1;
        case (instr_q)
          InstrAdd: begin
            operation        = OpAdd;
            flags_reg_enable = 1'b1;
          end
          InstrSub: begin
            operation        = OpSub;
            flags_reg_enable = 1'b1;
          end
          InstrAnd: begin
            operation        = OpAnd;
            flags_reg_enable = 1'b1;
          end
          InstrOr: begin
            operation        = OpOr;
            flags_reg_enable = 1'b1;
          end
          // MOVE: source is routed to both ALU inputs, so OR passes it through.
          InstrMove: operation = OpOr;
          default:   operation = OpAdd;
        endcase
      end
      StLoadAddr: addr_sel = 1'b1;
      StLoadWb: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      StStore: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      StBranch: begin
        branch    = 1'b1;
        pc_enable = 1'b1;
      end
      StHalt:  halt = 1'b1;
      default: ;
    endcase
  end

endmodule
